// File: rtl/coprocessor_io_pkg.sv
// rtl/coprocessor_io_pkg.sv - shared constants for the coprocessor_io input blocks
package coprocessor_io_pkg;

  typedef logic [1:0] reg_addr_t;

  localparam reg_addr_t ADDR_DATA    = 2'd0;
  localparam reg_addr_t ADDR_RSVD    = 2'd1;
  localparam reg_addr_t ADDR_IRQMASK = 2'd2;
  localparam reg_addr_t ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/coprocessor_io_sync_vec.sv
// rtl/coprocessor_io_sync_vec.sv - multi-stage vector synchroniser with async active-low reset
module coprocessor_io_sync_vec #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign sync_out = stage[SYNC_STAGES-1];

endmodule

// File: rtl/coprocessor_io_pio_in_edge.sv
// rtl/coprocessor_io_pio_in_edge.sv - input PIO slave with edge capture and maskable irq
module coprocessor_io_pio_in_edge
  import coprocessor_io_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int IRQ_MODE    = IRQ_EDGE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] PRIME_DONE = CNT_W'(SYNC_STAGES);

  logic [WIDTH-1:0] sync_data;
  logic [WIDTH-1:0] prev_sample;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [CNT_W-1:0] prime_cnt;
  logic             detect_en;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] clr_vec;
  logic [WIDTH-1:0] irq_src;
  logic [31:0]      rd_next;
  logic             wr_mask;
  logic             wr_edgecap;
  logic             unused_wdata;

  coprocessor_io_sync_vec #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (in_port),
    .sync_out (sync_data)
  );

  // prev_sample only holds a fully synchronised value one cycle after the
  // counter saturates, so detection is enabled from that point on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt <= '0;
      detect_en <= 1'b0;
    end else begin
      if (prime_cnt != PRIME_DONE) begin
        prime_cnt <= prime_cnt + CNT_W'(1);
      end
      detect_en <= (prime_cnt == PRIME_DONE);
    end
  end

  always_comb begin
    rise = sync_data & ~prev_sample;
    fall = ~sync_data & prev_sample;
    case (EDGE_MODE)
      EDGE_FALL: edge_vec = fall;
      EDGE_ANY:  edge_vec = rise | fall;
      default:   edge_vec = rise;
    endcase
  end

  assign wr_mask    = chipselect && write && (address == ADDR_IRQMASK);
  assign wr_edgecap = chipselect && write && (address == ADDR_EDGECAP);
  assign clr_vec    = wr_edgecap ? writedata[WIDTH-1:0] : '0;
  assign irq_src    = (IRQ_MODE == IRQ_EDGE) ? edgecapture : sync_data;
  assign unused_wdata = ^writedata;

  // A new edge overrides a same-cycle write-1-to-clear of that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_sample <= '0;
      edgecapture <= '0;
      irqmask     <= '0;
      irq         <= 1'b0;
    end else begin
      prev_sample <= sync_data;
      edgecapture <= (edgecapture & ~clr_vec) | (detect_en ? edge_vec : '0);
      if (wr_mask) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      irq <= |(irq_src & irqmask);
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = sync_data;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecapture;
      default:      rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_coprocessor_io_pio_in_edge.sv
// tb/tb_coprocessor_io_pio_in_edge.sv - self-checking bench for coprocessor_io_pio_in_edge
module tb_coprocessor_io_pio_in_edge;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [7:0]  in0, in1;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coprocessor_io_pio_in_edge #(
    .WIDTH(8), .SYNC_STAGES(S), .EDGE_MODE(0), .IRQ_MODE(1)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0)
  );

  coprocessor_io_pio_in_edge #(
    .WIDTH(8), .SYNC_STAGES(S), .EDGE_MODE(2), .IRQ_MODE(0)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: synchronised value is the input seen S edges earlier, edges are
  // compared only between two samples taken after reset release.
  logic [7:0]  h0[$];
  logic [7:0]  h1[$];
  int          post_edges;
  logic [7:0]  m_cap0, m_cap1, m_mask0, m_mask1;
  logic        m_irq0, m_irq1;
  logic [31:0] m_rd0, m_rd1;
  logic [7:0]  s0, s1, e0, e1, clr;

  function automatic logic [31:0] read_model(input logic [1:0] a, input logic [7:0] syncv,
                                             input logic [7:0] mask, input logic [7:0] cap);
    case (a)
      2'd0:    return {24'h0, syncv};
      2'd2:    return {24'h0, mask};
      2'd3:    return {24'h0, cap};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cap0 = 8'h00; m_cap1 = 8'h00; m_mask0 = 8'h00; m_mask1 = 8'h00;
      m_irq0 = 1'b0;  m_irq1 = 1'b0;  m_rd0 = 32'h0;   m_rd1 = 32'h0;
      post_edges = 0;
      h0.delete();
      h1.delete();
    end else begin
      s0 = (post_edges >= S) ? h0[S-1] : 8'h00;
      s1 = (post_edges >= S) ? h1[S-1] : 8'h00;
      e0 = 8'h00;
      e1 = 8'h00;
      if (post_edges >= S + 1) begin
        e0 = s0 & ~h0[S];
        e1 = s1 ^ h1[S];
      end
      clr = (chipselect && write && address == 2'd3) ? writedata[7:0] : 8'h00;
      m_rd0  = read_model(address, s0, m_mask0, m_cap0);
      m_rd1  = read_model(address, s1, m_mask1, m_cap1);
      m_irq0 = |(m_cap0 & m_mask0);
      m_irq1 = |(s1 & m_mask1);
      m_cap0 = (m_cap0 & ~clr) | e0;
      m_cap1 = (m_cap1 & ~clr) | e1;
      if (chipselect && write && address == 2'd2) begin
        m_mask0 = writedata[7:0];
        m_mask1 = writedata[7:0];
      end
      h0.push_front(in0);
      h1.push_front(in1);
      if (h0.size() > S + 1) begin
        void'(h0.pop_back());
        void'(h1.pop_back());
      end
      post_edges++;
    end
  end

  always @(negedge clk) begin
    check("model_rd0", rd0, m_rd0);
    check("model_irq0", 32'(irq0), 32'(m_irq0));
    check("model_rd1", rd1, m_rd1);
    check("model_irq1", 32'(irq1), 32'(m_irq1));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    tick(1);
    chipselect = 1'b0; write = 1'b0; writedata = 32'h0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] r0, output logic [31:0] r1);
    address = a; chipselect = 1'b1; write = 1'b0;
    tick(1);
    r0 = rd0; r1 = rd1;
    chipselect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; address = 2'd0; writedata = 32'h0;
    in0 = 8'hFF; in1 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd0", rd0, 32'h0);
    check("reset_irq0", 32'(irq0), 32'h0);
    reset_n = 1'b1;
    tick(10);

    rd(2'd3, a, b); check("prime_cap0", a, 32'h0);
    rd(2'd0, a, b); check("prime_data0", a, 32'h000000FF);
    check("prime_irq0", 32'(irq0), 32'h0);

    in0 = 8'h00; tick(5);
    rd(2'd3, a, b); check("fall_ignored_cap0", a, 32'h0);
    in0 = 8'h05; tick(S + 1);
    rd(2'd3, a, b); check("rise_cap0", a, 32'h00000005);

    wr(2'd3, 32'h00000001);
    rd(2'd3, a, b); check("w1c_cap0", a, 32'h00000004);
    in0 = 8'h01; tick(4);
    in0 = 8'h05; tick(2);
    wr(2'd3, 32'h00000004);
    rd(2'd3, a, b); check("collision_cap0", a, 32'h00000004);
    wr(2'd3, 32'h00000004);
    rd(2'd3, a, b); check("cleared_cap0", a, 32'h0);

    wr(2'd2, 32'h00000004);
    in0 = 8'h01; tick(4);
    in0 = 8'h05; tick(3);
    check("irq0_before", 32'(irq0), 32'h0);
    tick(1);
    check("irq0_set", 32'(irq0), 32'h1);
    wr(2'd3, 32'h00000004);
    check("irq0_hold", 32'(irq0), 32'h1);
    tick(1);
    check("irq0_clr", 32'(irq0), 32'h0);
    in0 = 8'h04; tick(4);
    in0 = 8'h05; tick(6);
    check("irq0_masked", 32'(irq0), 32'h0);
    rd(2'd3, a, b); check("bit0_cap0", a, 32'h00000001);

    wr(2'd2, 32'h00000080);
    wr(2'd3, 32'h000000FF);
    in1 = 8'h80; tick(2);
    check("lvl_irq1_lo", 32'(irq1), 32'h0);
    tick(1);
    check("lvl_irq1_hi", 32'(irq1), 32'h1);
    rd(2'd3, a, b); check("any_rise_cap1", b, 32'h00000080);
    wr(2'd3, 32'h00000080);
    rd(2'd3, a, b); check("any_clr_cap1", b, 32'h0);
    in1 = 8'h00; tick(2);
    check("lvl_irq1_hold", 32'(irq1), 32'h1);
    tick(1);
    check("lvl_irq1_drop", 32'(irq1), 32'h0);
    rd(2'd3, a, b); check("any_fall_cap1", b, 32'h00000080);

    in0 = 8'h00; tick(4);
    wr(2'd3, 32'h000000FF);
    in0 = 8'hAA; tick(3);
    wr(2'd2, 32'h000000FF);
    tick(1);
    check("pre_rst_irq0", 32'(irq0), 32'h1);
    rd(2'd3, a, b); check("pre_rst_cap0", a, 32'h000000AA);
    @(posedge clk);
    #2;
    check("pre_rst_rd0", rd0, 32'h000000AA);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rd0", rd0, 32'h0);
    check("async_irq0", 32'(irq0), 32'h0);
    check("async_rd1", rd1, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    rd(2'd2, a, b); check("post_rst_mask0", a, 32'h0);
    rd(2'd3, a, b); check("post_rst_cap0", a, 32'h0);
    rd(2'd0, a, b); check("post_rst_data0", a, 32'h000000AA);
    rd(2'd1, a, b); check("rsvd_rd0", a, 32'h0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
